som_dec_seq: RTL and testbench

SOM_DEC_SEQ -- requirements
Module: som_dec_seq

---
 rtl/som_dec_seq_pkg.sv | 16 +
 rtl/som_dec_nx2n.sv | 18 +
 rtl/som_dec_seq.sv | 119 +++++++++++
 tb/tb_som_dec_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/som_dec_seq_pkg.sv
// Shared definitions for the som_dec_seq decoder sequencer.
//   state_t          : sequencer FSM states
//   TT_RESET_DEFAULT : reset truth table for N=4, F = A(CD+B)+BC' (A = MSB)
package som_dec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SWEEP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Minterms 4,5,11,12,13,14,15 are set.
  localparam logic [15:0] TT_RESET_DEFAULT = 16'hF830;

endpackage

// File: rtl/som_dec_nx2n.sv
// Combinational N-to-2**N one-hot decoder with positive enable.
//   sel : select value
//   en  : enable; all outputs low when 0
//   dec : one-hot output, bit sel set when enabled
module som_dec_nx2n #(
  parameter int N = 4
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/som_dec_seq.sv
// Decoder sequencer: evaluates a programmable truth table either for a single
// select value or as a full sweep over all 2**N minterms, with a one-hot
// decode of the select value alongside each result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : evaluation enable, sampled in each result cycle
//   mode                : 0 = single evaluation, 1 = full sweep (sampled on accept)
//   in_valid/in_ready   : request handshake, in_data = select value (MSB = A)
//   tt_load/tt_data     : truth-table write, bit k = F for minterm k
//   out_valid, out_sel  : result strobe and the select value it belongs to
//   dec_out, f          : one-hot decode and truth-table bit at out_sel
//   sweep_done          : one-cycle pulse after the last sweep result
//   ones_count          : F=1 results counted during the last sweep
module som_dec_seq
  import som_dec_seq_pkg::*;
#(
  parameter int              N        = 4,
  parameter logic [2**N-1:0] TT_RESET = (2**N)'(TT_RESET_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            in_ready,
  input  logic            tt_load,
  input  logic [2**N-1:0] tt_data,
  output logic            out_valid,
  output logic [N-1:0]    out_sel,
  output logic [2**N-1:0] dec_out,
  output logic            f,
  output logic            sweep_done,
  output logic [N:0]      ones_count
);

  localparam logic [N-1:0] LAST = '1;

  state_t          state, state_nx;
  logic [2**N-1:0] tt;     // live truth table
  logic [2**N-1:0] snap;   // table captured at accept; all results read from it
  logic [N-1:0]    sel;    // doubles as sweep index
  logic [N:0]      ones;
  logic            accept;
  logic            hit;

  assign accept = in_valid & in_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sweep_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = mode ? SWEEP : SINGLE;
      end
      SINGLE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      SWEEP: begin
        out_valid = 1'b1;
        if (sel == LAST) state_nx = DONE;
      end
      DONE: begin
        sweep_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Results are combinational from the registered select and snapshot so en
  // acts on exactly the cycle in which it is presented.
  assign hit = out_valid & en & snap[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt   <= TT_RESET;
      snap <= '0;
      sel  <= '0;
      ones <= '0;
    end else begin
      if (tt_load) tt <= tt_data;
      if (accept) begin
        // Snapshot takes the pre-load table when tt_load coincides with accept.
        snap <= tt;
        if (mode) begin
          sel  <= '0;
          ones <= '0;
        end else begin
          sel  <= in_data;
        end
      end else if (state == SWEEP) begin
        if (hit)         ones <= ones + 1'b1;
        if (sel != LAST) sel  <= sel + 1'b1;
      end
    end
  end

  som_dec_nx2n #(.N(N)) u_dec (
    .sel (sel),
    .en  (out_valid & en),
    .dec (dec_out)
  );

  assign f          = hit;
  assign out_sel    = sel;
  assign ones_count = ones;

endmodule

// File: tb/tb_som_dec_seq.sv
// Directed self-checking bench for som_dec_seq (N=4, default truth table).
module tb_som_dec_seq;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, mode, in_valid, tt_load;
  logic [N-1:0]  in_data;
  logic [15:0]   tt_data;
  logic          in_ready, out_valid, f, sweep_done;
  logic [N-1:0]  out_sel;
  logic [15:0]   dec_out;
  logic [N:0]    ones_count;

  int errors = 0;
  int checks = 0;

  som_dec_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tt_load    (tt_load),
    .tt_data    (tt_data),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .dec_out    (dec_out),
    .f          (f),
    .sweep_done (sweep_done),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".dec_out"},   32'(dec_out),   32'd0);
    chk({tag, ".f"},         32'(f),         32'd0);
  endtask

  initial begin
    logic [15:0] ref_tt;
    logic [15:0] one;
    int          cnt;

    rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    tt_load = 1'b0; tt_data = '0;
    #1;
    // ---- reset state ----
    chk_idle_outs("rst");
    chk("rst.out_sel",    32'(out_sel),    32'd0);
    chk("rst.sweep_done", 32'(sweep_done), 32'd0);
    chk("rst.ones_count", 32'(ones_count), 32'd0);
    chk("rst.in_ready",   32'(in_ready),   32'd1);
    step();
    rst_n = 1'b1;
    step();

    // ---- SINGLE, en=1, 1011 ----
    in_valid = 1'b1; mode = 1'b0; in_data = 4'b1011;
    step();
    in_valid = 1'b0;
    chk("s1.out_valid", 32'(out_valid), 32'd1);
    chk("s1.dec_out",   32'(dec_out),   32'h0800);
    chk("s1.f",         32'(f),         32'd1);
    chk("s1.out_sel",   32'(out_sel),   32'd11);
    chk("s1.in_ready",  32'(in_ready),  32'd0);
    step();
    chk_idle_outs("s1.after");
    chk("s1.sel_hold", 32'(out_sel),  32'd11);
    chk("s1.ready",    32'(in_ready), 32'd1);

    // ---- SINGLE, en=0, 0100 ----
    in_valid = 1'b1; in_data = 4'b0100; en = 1'b0;
    step();
    in_valid = 1'b0;
    chk("s2.out_valid", 32'(out_valid), 32'd1);
    chk("s2.dec_out",   32'(dec_out),   32'd0);
    chk("s2.f",         32'(f),         32'd0);
    step();
    en = 1'b1;

    // ---- sweep, default table ----
    ref_tt = 16'hF830;
    in_valid = 1'b1; mode = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      one = 16'd1 << i;
      chk($sformatf("sw1.valid[%0d]", i), 32'(out_valid),  32'd1);
      chk($sformatf("sw1.sel[%0d]", i),   32'(out_sel),    32'(i));
      chk($sformatf("sw1.dec[%0d]", i),   32'(dec_out),    32'(one));
      chk($sformatf("sw1.f[%0d]", i),     32'(f),          32'(ref_tt[i]));
      chk($sformatf("sw1.done[%0d]", i),  32'(sweep_done), 32'd0);
      step();
    end
    chk("sw1.sweep_done", 32'(sweep_done), 32'd1);
    chk("sw1.ones",       32'(ones_count), 32'd7);
    chk("sw1.done_valid", 32'(out_valid),  32'd0);
    step();
    chk("sw1.done_pulse", 32'(sweep_done), 32'd0);
    chk("sw1.ones_hold",  32'(ones_count), 32'd7);
    chk("sw1.ready",      32'(in_ready),   32'd1);

    // ---- tt_load on sweep accept: snapshot is pre-load table ----
    in_valid = 1'b1; mode = 1'b1; tt_load = 1'b1; tt_data = 16'hFFFF;
    step();
    in_valid = 1'b0; tt_load = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sw2.f[%0d]", i), 32'(f), 32'(ref_tt[i]));
      step();
    end
    chk("sw2.sweep_done", 32'(sweep_done), 32'd1);
    chk("sw2.ones",       32'(ones_count), 32'd7);
    step();
    in_valid = 1'b1; mode = 1'b0; in_data = 4'd0;
    step();
    in_valid = 1'b0;
    chk("s3.f_new_tt", 32'(f),       32'd1);
    chk("s3.dec",      32'(dec_out), 32'h0001);
    step();

    // ---- sweep with en=0 on indices 12..15 ----
    tt_load = 1'b1; tt_data = 16'hF830;
    step();
    tt_load = 1'b0;
    in_valid = 1'b1; mode = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = (i < 12);
      #1;
      one = (i < 12) ? (16'd1 << i) : 16'd0;
      chk($sformatf("sw3.valid[%0d]", i), 32'(out_valid), 32'd1);
      chk($sformatf("sw3.dec[%0d]", i),   32'(dec_out),   32'(one));
      chk($sformatf("sw3.f[%0d]", i),     32'(f),         32'((i < 12) ? ref_tt[i] : 1'b0));
      step();
    end
    en = 1'b1;
    chk("sw3.sweep_done", 32'(sweep_done), 32'd1);
    chk("sw3.ones",       32'(ones_count), 32'd3);
    step();

    // ---- reset mid-sweep; requests during the sweep are ignored ----
    in_valid = 1'b1; mode = 1'b1;
    step();
    mode = 1'b0; in_data = 4'd3;          // keep in_valid high: must be ignored
    tt_load = 1'b1; tt_data = 16'hFFFF;   // running sweep keeps its snapshot
    step();
    tt_load = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk("rs.sel8",   32'(out_sel),   32'd8);
    chk("rs.valid8", 32'(out_valid), 32'd1);
    chk("rs.f8",     32'(f),         32'd0);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk_idle_outs("rs.async");
    chk("rs.out_sel",    32'(out_sel),    32'd0);
    chk("rs.sweep_done", 32'(sweep_done), 32'd0);
    chk("rs.ones",       32'(ones_count), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (sweep_done !== 1'b0 || out_valid !== 1'b0) cnt++;
      step();
    end
    chk("rs.no_done", 32'(cnt),      32'd0);
    chk("rs.ready",   32'(in_ready), 32'd1);
    // table back to reset value: minterm 0 -> 0, minterm 4 -> 1
    in_valid = 1'b1; mode = 1'b0; in_data = 4'd0;
    step();
    in_valid = 1'b0;
    chk("rs.tt_m0", 32'(f), 32'd0);
    step();
    in_valid = 1'b1; in_data = 4'd4;
    step();
    in_valid = 1'b0;
    chk("rs.tt_m4", 32'(f),       32'd1);
    chk("rs.dec4",  32'(dec_out), 32'h0010);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
